seq_stim_ctrl: RTL and testbench

Sequencing controller for a serial sequence detector (single-bit input x, single-bit match output z). On a start command it clears the detector, shifts a programmed bit pattern into it one bit per clock, then drains. It counts detector matches over the run and reports completion with a one-cycle done pulse. It sits between a register/command interface and the detector instance, replacing hand-written stimulus sequences with a programmable run.

---
 rtl/seq_stim_ctrl.sv | 136 +++++++++++++
 tb/tb_seq_stim_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_stim_ctrl.sv
// Sequencing controller for a serial sequence detector: clears it, shifts a
// programmed pattern LSB-first, drains, and counts detector matches over the run.
module seq_stim_ctrl #(
  parameter int MAXLEN    = 16,
  parameter int LW        = 5,
  parameter int CW        = 5,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LW-1:0]     len,
  input  logic              det_z,
  output logic              det_x,
  output logic              det_clr,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     match_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);
  localparam logic [2:0]    DLAST_L  = 3'(DRAIN_CYC - 1);

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] sreg_q, sreg_d;
  logic [LW-1:0]     bcnt_q, bcnt_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic              det_x_q, det_x_d;
  logic [CW-1:0]     mcnt_q, mcnt_d;
  logic [LW-1:0]     len_cl_s;

  assign len_cl_s = (len > MAXLEN_L) ? MAXLEN_L : len;

  // State, shift register, counters and the registered det_x
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      dcnt_q  <= 3'd0;
      det_x_q <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      det_x_q <= det_x_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next-state logic; det_x_d is the bit the detector sees in the next cycle
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    det_x_d = 1'b0;
    mcnt_d  = mcnt_q;

    // det_z counts at any edge taken in SHIFT/DRAIN, including an aborting one
    if ((state_q == S_SHIFT || state_q == S_DRAIN) && det_z && (mcnt_q != {CW{1'b1}})) begin
      mcnt_d = mcnt_q + CW'(1);
    end else begin
      mcnt_d = mcnt_q;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcnt_d = '0;
            if (len == '0) begin
              state_d = S_DONE;
            end else begin
              sreg_d  = pattern;
              // bcnt holds the bits still to present after the one on det_x
              bcnt_d  = len_cl_s - LW'(1);
              state_d = S_CLEAR;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLEAR: begin
          det_x_d = sreg_q[0];
          sreg_d  = sreg_q >> 1;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (bcnt_q == '0) begin
            if (DRAIN_CYC > 0) begin
              dcnt_d  = DLAST_L;
              state_d = S_DRAIN;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            det_x_d = sreg_q[0];
            sreg_d  = sreg_q >> 1;
            bcnt_d  = bcnt_q - LW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == 3'd0) begin
            state_d = S_DONE;
          end else begin
            dcnt_d = dcnt_q - 3'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign det_x       = det_x_q;
  assign det_clr     = (state_q == S_CLEAR);
  assign busy        = (state_q == S_CLEAR) || (state_q == S_SHIFT) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign match_count = mcnt_q;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Self-checking bench for seq_stim_ctrl: table-driven runs against a per-cycle
// scoreboard, plus hand sequences for async reset, abort, ignored start and saturation.
module tb_seq_stim_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start3, abort;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        zmode_one;
  logic        det_z;
  logic        det_x, det_clr, busy, done;
  logic [4:0]  match_count;
  logic        det_x3, det_clr3, busy3, done3;
  logic [2:0]  match_count3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic        zone;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;

  vec_t       vecs[9];
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  assign det_z = zmode_one ? 1'b1 : det_x;

  seq_stim_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .det_z(det_z), .det_x(det_x), .det_clr(det_clr), .busy(busy),
    .done(done), .match_count(match_count)
  );

  seq_stim_ctrl #(.CW(3), .DRAIN_CYC(0)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort), .pattern(pattern),
    .len(len), .det_z(det_x3), .det_x(det_x3), .det_clr(det_clr3), .busy(busy3),
    .done(done3), .match_count(match_count3)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int         n;
    logic [3:0] e;
    logic [3:0] a;
    n = (v.len > 5'd16) ? 16 : int'(v.len);
    // Expected {det_x, det_clr, busy, done} for each cycle after the start edge
    for (int c = 1; c <= v.exp_lat; c++) begin
      if (n == 0)                e = 4'b0001;
      else if (c == 1)           e = 4'b0110;
      else if (c <= n + 1)       e = {v.pat[c-2], 3'b010};
      else if (c == v.exp_lat)   e = 4'b0001;
      else                       e = 4'b0010;
      sb_q.push_back(e);
    end
    @(negedge clk);
    zmode_one = v.zone;
    pattern   = v.pat;
    len       = v.len;
    start     = 1'b1;
    for (int c = 1; c <= v.exp_lat; c++) begin
      @(negedge clk);
      start = 1'b0;
      a = {det_x, det_clr, busy, done};
      e = sb_q.pop_front();
      check($sformatf("vec%0d cyc%0d x/clr/busy/done", idx, c), int'(a), int'(e));
    end
    check($sformatf("vec%0d match_count", idx), int'(match_count), v.exp_cnt);
    @(negedge clk);
    check($sformatf("vec%0d idle after done", idx), int'({busy, done, det_clr}), 0);
    check($sformatf("vec%0d count holds", idx), int'(match_count), v.exp_cnt);
    zmode_one = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    logic [15:0] ab_pat;
    reset = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0;
    pattern = 16'h0000; len = 5'd0; zmode_one = 1'b0;

    #1;
    check("reset outputs", int'({det_x, det_clr, busy, done}), 0);
    check("reset match_count", int'(match_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    vecs[0] = '{16'h00B5, 5'd8,  1'b0, 5,  12};
    vecs[1] = '{16'hFFFF, 5'd20, 1'b0, 16, 20};
    vecs[2] = '{16'h1234, 5'd0,  1'b0, 0,  1};
    vecs[3] = '{16'h8001, 5'd16, 1'b0, 2,  20};
    vecs[4] = '{16'h0002, 5'd1,  1'b0, 0,  5};
    vecs[5] = '{16'h0001, 5'd1,  1'b0, 1,  5};
    vecs[6] = '{16'hA5A5, 5'd16, 1'b0, 8,  20};
    vecs[7] = '{16'h00FF, 5'd4,  1'b0, 4,  8};
    vecs[8] = '{16'h0000, 5'd3,  1'b1, 5,  7};
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of a 16-bit run
    @(negedge clk);
    pattern = 16'hFFFF; len = 5'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun busy before reset", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("async reset outputs", int'({det_x, det_clr, busy, done}), 0);
    check("async reset match_count", int'(match_count), 0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[0], 100);

    // Start pulsed in SHIFT is ignored; abort while bit 4 is on det_x
    ab_pat = 16'h00EF;
    for (int c = 1; c <= 9; c++) begin
      if (c == 1)      e = 4'b0110;
      else if (c <= 6) e = {ab_pat[c-2], 3'b010};
      else             e = 4'b0000;
      sb_q.push_back(e);
    end
    @(negedge clk);
    pattern = ab_pat; len = 5'd8; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("abort cyc%0d x/clr/busy/done", c), int'({det_x, det_clr, busy, done}), int'(e));
      start = (c == 3);
      abort = (c == 6);
    end
    check("abort partial match_count", int'(match_count), 4);

    // abort and start together in IDLE: start is dropped
    pattern = 16'hFFFF; len = 5'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort+start no run", int'({det_x, det_clr, busy, done}), 0);
    check("abort+start count kept", int'(match_count), 4);
    @(negedge clk);
    check("abort+start still idle", int'({det_x, det_clr, busy, done}), 0);

    // Saturating 3-bit counter, no drain cycles
    pattern = 16'hFFFF; len = 5'd16; start3 = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (c == 1)  check("cw3 det_clr", int'(det_clr3), 1);
      if (c == 8)  check("cw3 count mid", int'(match_count3), 6);
      if (c == 17) check("cw3 busy/done before end", int'({busy3, done3}), 2);
      if (c == 18) check("cw3 done", int'(done3), 1);
      if (c == 18) check("cw3 saturated", int'(match_count3), 7);
      if (c == 19) check("cw3 after done", int'({done3, match_count3}), 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
